// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

    // Where the most recent PC update came from.
    typedef enum logic [1:0] {
        PC_SEQ   = 2'd0,
        PC_REDIR = 2'd1,
        PC_TRAP  = 2'd2,
        PC_RAS   = 2'd3
    } pc_src_t;

    // Default PC after reset.
    localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Low address bits that must be zero for an instruction of the given size:
    // bit 0 for compressed (2-byte) fetch, bits [1:0] for 4-byte fetch.
    function automatic logic [1:0] align_low_mask(input int unsigned instr_bytes);
        return (instr_bytes == 2) ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack. The write pointer always addresses the slot
// for the next push, so the top of stack sits one entry below it. When full,
// that slot holds the oldest entry, which a further push overwrites.
module return_address_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] top_idx;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;

    assign top_idx  = wr_ptr_q - 1'b1;
    assign top      = mem_q[top_idx];
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;

    // Next pointer/count/overflow and the memory write port for this cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q;

        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (push && pop && !empty) begin
            // Return followed by a call: replace the top in place.
            mem_we    = 1'b1;
            mem_waddr = top_idx;
        end else if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL_COUNT) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && !empty) begin
            wr_ptr_d = wr_ptr_q - 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    // Stack bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is assigned with <= so every register samples the pre-edge values of the others.
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage.
    // NOTE: the storage array has no reset; the count alone says which entries are valid, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= push_addr;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: picks the next PC from trap, redirect,
// predicted return or sequential increment, and aligns taken targets.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_DEFAULT_RESET_VECTOR),
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     RAS_DEPTH    = 4
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pc_write,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_seq,
    output logic [1:0]      pc_src,
    output logic            ras_empty,
    output logic            ras_overflow,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] PC_INC   = XLEN'(INSTR_BYTES);
    localparam logic [1:0]      LOW_MASK = align_low_mask(INSTR_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    pc_src_t         src_q, src_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] ras_top;
    logic            ras_push_en;
    logic            ras_pop_en;
    logic            take_target;
    logic [XLEN-1:0] target;

    // A trap flushes the stack and drops same-cycle calls/returns; otherwise
    // calls and returns follow the stall.
    assign ras_push_en = ras_push && pc_write && !trap_valid;
    assign ras_pop_en  = ras_pop  && pc_write && !trap_valid;

    return_address_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push_en),
        .pop       (ras_pop_en),
        .clear     (trap_valid),
        .push_addr (ras_push_addr),
        .top       (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow)
    );

    assign pc_seq       = pc_q + PC_INC;
    assign pc_current   = pc_q;
    assign pc_src       = src_q;
    assign misalign_err = misalign_q;

    // Priority mux for the next PC, with alignment of non-sequential targets.
    always_comb begin
        pc_d        = pc_q;
        src_d       = src_q;
        take_target = 1'b0;
        target      = '0;

        if (trap_valid) begin
            take_target = 1'b1;
            target      = trap_vector;
            src_d       = PC_TRAP;
        end else if (redirect_valid) begin
            take_target = 1'b1;
            target      = redirect_target;
            src_d       = PC_REDIR;
        end else if (pc_write && ras_pop && !ras_empty) begin
            take_target = 1'b1;
            target      = ras_top;
            src_d       = PC_RAS;
        end else if (pc_write) begin
            pc_d  = pc_seq;
            src_d = PC_SEQ;
        end

        misalign_d = take_target && ((target[1:0] & LOW_MASK) != 2'b00);
        if (take_target) begin
            pc_d      = target;
            pc_d[1:0] = target[1:0] & ~LOW_MASK;
        end
    end

    // PC, source and misalignment pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_VECTOR;
            src_q      <= PC_SEQ;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            src_q      <= src_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        pc_write;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc_current;
    logic [31:0] pc_seq;
    logic [1:0]  pc_src;
    logic        ras_empty;
    logic        ras_overflow;
    logic        misalign_err;

    int tests_run    = 0;
    int tests_failed = 0;

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc_write        (pc_write),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ras_push        (ras_push),
        .ras_push_addr   (ras_push_addr),
        .ras_pop         (ras_pop),
        .pc_current      (pc_current),
        .pc_seq          (pc_seq),
        .pc_src          (pc_src),
        .ras_empty       (ras_empty),
        .ras_overflow    (ras_overflow),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] pc, input logic [1:0] src);
        check({tag, ".pc"}, pc_current, pc);
        check({tag, ".src"}, {30'd0, pc_src}, {30'd0, src});
    endtask

    localparam logic [31:0] ras_addrs [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};

    initial begin
        reset_n = 1'b0; pc_write = 1'b0;
        trap_valid = 1'b0; trap_vector = '0;
        redirect_valid = 1'b0; redirect_target = '0;
        ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;

        // Reset state.
        #3;
        check_pc("reset", 32'h0, 2'd0);
        check("reset.pc_seq", pc_seq, 32'h4);
        check("reset.empty", {31'd0, ras_empty}, 32'd1);
        check("reset.ovf", {31'd0, ras_overflow}, 32'd0);
        check("reset.mis", {31'd0, misalign_err}, 32'd0);
        tick();
        reset_n = 1'b1;

        // Sequential advance.
        pc_write = 1'b1;
        tick(); check_pc("seq1", 32'h4, 2'd0);
        tick(); check_pc("seq2", 32'h8, 2'd0);
        tick(); check_pc("seq3", 32'hC, 2'd0);

        // Asynchronous reset mid-run.
        reset_n = 1'b0;
        #1;
        check("async_reset.pc", pc_current, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) tick();
        check_pc("to_0x10", 32'h10, 2'd0);

        // Stall holds.
        pc_write = 1'b0;
        tick(); check_pc("stall1", 32'h10, 2'd0);
        tick(); check_pc("stall2", 32'h10, 2'd0);

        // Redirect overrides stall.
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick(); check_pc("redir_stall", 32'h200, 2'd1);
        redirect_valid = 1'b0;

        // Put one entry on the stack so the trap flush is visible.
        pc_write = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h500;
        tick(); check_pc("push500", 32'h204, 2'd0);
        check("push500.empty", {31'd0, ras_empty}, 32'd0);

        // Trap beats redirect and clears the stack; same-cycle push ignored.
        trap_valid = 1'b1; trap_vector = 32'h80;
        redirect_valid = 1'b1; redirect_target = 32'h300;
        ras_push_addr = 32'h900;
        tick(); check_pc("trap", 32'h80, 2'd2);
        check("trap.empty", {31'd0, ras_empty}, 32'd1);
        check("trap.mis", {31'd0, misalign_err}, 32'd0);
        trap_valid = 1'b0; redirect_valid = 1'b0;

        // Push two, pop three.
        ras_push_addr = 32'h104;
        tick(); check_pc("push104", 32'h84, 2'd0);
        ras_push_addr = 32'h208;
        tick(); check_pc("push208", 32'h88, 2'd0);
        ras_push = 1'b0; ras_pop = 1'b1;
        tick(); check_pc("pop1", 32'h208, 2'd3);
        check("pop1.empty", {31'd0, ras_empty}, 32'd0);
        tick(); check_pc("pop2", 32'h104, 2'd3);
        check("pop2.empty", {31'd0, ras_empty}, 32'd1);
        tick(); check_pc("pop3_empty", 32'h108, 2'd0);
        check("pop3.mis", {31'd0, misalign_err}, 32'd0);
        ras_pop = 1'b0;

        // Overflow: five pushes into a four-deep stack.
        ras_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ras_push_addr = ras_addrs[i];
            tick();
            check("ovf_push.pc", pc_current, 32'h10C + 32'(i) * 32'd4);
            check("ovf_push.flag", {31'd0, ras_overflow}, (i == 4) ? 32'd1 : 32'd0);
        end
        ras_push = 1'b0; ras_pop = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_pc("ovf_pop", ras_addrs[i], 2'd3);
        end
        tick(); check_pc("ovf_pop5", 32'h2004, 2'd0);
        check("ovf_sticky", {31'd0, ras_overflow}, 32'd1);

        // Push+pop while empty acts as a push only.
        ras_push = 1'b1; ras_push_addr = 32'h600;
        tick(); check_pc("pushpop_empty", 32'h2008, 2'd0);
        check("pushpop_empty.empty", {31'd0, ras_empty}, 32'd0);
        // Push+pop with one entry: old top taken, top replaced.
        ras_push_addr = 32'h700;
        tick(); check_pc("pushpop", 32'h600, 2'd3);
        check("pushpop.empty", {31'd0, ras_empty}, 32'd0);
        ras_push = 1'b0;
        tick(); check_pc("pop_replaced", 32'h700, 2'd3);
        check("pop_replaced.empty", {31'd0, ras_empty}, 32'd1);
        ras_pop = 1'b0;

        // Misaligned redirect: aligned PC and one-cycle error pulse.
        redirect_valid = 1'b1; redirect_target = 32'h0000_0403;
        tick(); check_pc("mis_redir", 32'h400, 2'd1);
        check("mis_redir.err", {31'd0, misalign_err}, 32'd1);
        redirect_valid = 1'b0;
        tick(); check_pc("mis_after", 32'h404, 2'd0);
        check("mis_after.err", {31'd0, misalign_err}, 32'd0);

        // Misaligned trap vector.
        trap_valid = 1'b1; trap_vector = 32'h82;
        tick(); check_pc("mis_trap", 32'h80, 2'd2);
        check("mis_trap.err", {31'd0, misalign_err}, 32'd1);
        trap_valid = 1'b0;

        // Wrap-around at the top of the address space.
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick(); check_pc("wrap_setup", 32'hFFFF_FFFC, 2'd1);
        check("wrap.pc_seq", pc_seq, 32'h0);
        check("wrap_setup.err", {31'd0, misalign_err}, 32'd0);
        redirect_valid = 1'b0;
        tick(); check_pc("wrap", 32'h0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
